// File: rtl/display_counter_if.sv
// Button/switch inputs and count outputs of the display counter front end.
// The master side drives buttons and switches; the slave side is the counter.
interface display_counter_if;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_load;
    logic [4:0] load_val;
    logic [4:0] count;
    logic       wrapped;

    modport master (
        output btn_inc,
        output btn_dec,
        output btn_load,
        output load_val,
        input  count,
        input  wrapped
    );

    modport slave (
        input  btn_inc,
        input  btn_dec,
        input  btn_load,
        input  load_val,
        output count,
        output wrapped
    );
endinterface

// File: rtl/display_counter.sv
// Synchronizes and debounces three push-buttons and keeps a 5-bit wrapping
// count (load / inc / dec) that feeds the two-digit seven-segment converter.
module display_counter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    display_counter_if.slave bus
);
    localparam int NBTN     = 3;
    localparam int BTN_INC  = 0;
    localparam int BTN_DEC  = 1;
    localparam int BTN_LOAD = 2;
    localparam logic [7:0] DCNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC
    } action_e;

    logic [NBTN-1:0] w_btn_raw;
    logic [NBTN-1:0] r_s1;
    logic [NBTN-1:0] r_s2;
    logic [NBTN-1:0] w_stable;
    logic [NBTN-1:0] r_stable_d;
    logic [NBTN-1:0] w_press;

    assign w_btn_raw = {bus.btn_load, bus.btn_dec, bus.btn_inc};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (s1 -> s2 stays a 2-stage chain).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stable_d <= '0;
        end else begin
            r_s1       <= w_btn_raw;
            r_s2       <= r_s1;
            r_stable_d <= w_stable;
        end
    end

    // A level change is accepted only after D consecutive differing samples;
    // any return to the old level restarts the count.
    for (genvar g = 0; g < NBTN; g++) begin : g_debounce
        logic       r_stable;
        logic [7:0] r_dcnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_stable <= 1'b0;
                r_dcnt   <= '0;
            end else if (r_s2[g] == r_stable) begin
                r_dcnt   <= '0;
            end else if (r_dcnt == DCNT_LAST) begin
                r_stable <= r_s2[g];
                r_dcnt   <= '0;
            end else begin
                r_dcnt   <= r_dcnt + 8'd1;
            end
        end

        assign w_stable[g] = r_stable;
    end

    assign w_press = w_stable & ~r_stable_d;

    action_e    w_action;
    logic [5:0] w_sum;
    logic [5:0] w_diff;
    logic [4:0] r_count;
    logic       r_wrapped;

    // Bit 5 carries the carry (inc) or borrow (dec) out of the 5-bit count.
    assign w_sum  = {1'b0, r_count} + 6'd1;
    assign w_diff = {1'b0, r_count} - 6'd1;

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_action = ACT_HOLD;
        if (w_press[BTN_LOAD]) begin
            w_action = ACT_LOAD;
        end else if (w_press[BTN_INC] && w_press[BTN_DEC]) begin
            w_action = ACT_HOLD;
        end else if (w_press[BTN_INC]) begin
            w_action = ACT_INC;
        end else if (w_press[BTN_DEC]) begin
            w_action = ACT_DEC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else begin
            case (w_action)
                ACT_LOAD: begin
                    r_count   <= bus.load_val;
                    r_wrapped <= 1'b0;
                end
                ACT_INC: begin
                    r_count   <= w_sum[4:0];
                    r_wrapped <= w_sum[5];
                end
                ACT_DEC: begin
                    r_count   <= w_diff[4:0];
                    r_wrapped <= w_diff[5];
                end
                default: begin
                    r_wrapped <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = r_count;
    assign bus.wrapped = r_wrapped;
endmodule

// File: tb/tb_display_counter.sv
// Bench for display_counter: table-driven presses plus hand sequences, with a
// cycle-stamped scoreboard compared against count/wrapped on every falling edge.
module tb_display_counter;
    localparam int D   = 4;
    localparam int LAT = D + 3;  // negedge drive -> negedge where new count is visible

    logic clk   = 1'b0;
    logic reset = 1'b0;

    display_counter_if bus ();

    display_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [4:0] cnt;
        logic       wr;
    } sb_t;

    typedef struct {
        logic       inc;
        logic       dec;
        logic       load;
        logic [4:0] val;
        logic [4:0] exp_count;
        logic       exp_wr;
    } vec_t;

    sb_t        sb_q[$];
    vec_t       vecs[12];
    int         cyc       = 0;
    int         checks    = 0;
    int         errors    = 0;
    logic       mon_en    = 1'b0;
    logic [4:0] exp_count = '0;
    logic       exp_wr    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected state changes only when a scoreboard entry falls due; wrapped is a one-cycle pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_wr = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_count = sb_q[0].cnt;
                exp_wr    = sb_q[0].wr;
                void'(sb_q.pop_front());
            end
            check("count", 32'(bus.count), 32'(exp_count));
            check("wrapped", 32'(bus.wrapped), 32'(exp_wr));
        end
    end

    task automatic async_reset(input int hold_cycles);
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb_q.delete();
        exp_count = '0;
        exp_wr    = 1'b0;
        #1;
        check("rst_count_async", 32'(bus.count), 32'd0);
        check("rst_wrapped_async", 32'(bus.wrapped), 32'd0);
        repeat (hold_cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press(input vec_t v, input int hold, input int gap);
        @(negedge clk);
        bus.load_val = v.val;
        bus.btn_inc  = v.inc;
        bus.btn_dec  = v.dec;
        bus.btn_load = v.load;
        sb_q.push_back('{cyc + LAT, v.exp_count, v.exp_wr});
        repeat (hold) @(negedge clk);
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        bus.btn_load = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            inc   dec   load  val     exp    wrap
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd2,  1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'd31, 5'd0,  1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'd31, 5'd31, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd31, 5'd30, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 5'd5,  5'd5,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd22, 5'd22, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd0,  1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd31, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 5'd7,  5'd7,  1'b0};

        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        bus.btn_load = 1'b0;
        bus.load_val = '0;

        // Reset between edges must clear outputs with no clock.
        async_reset(2);
        mon_en = 1'b1;

        // Long hold: exactly one increment, no auto-repeat.
        press('{1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0}, 20, 12);

        // Bounce: 3 cycles high, 1 low, five times; nothing may be accepted.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.btn_inc = 1'b1;
            repeat (3) @(negedge clk);
            bus.btn_inc = 1'b0;
        end
        repeat (12) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            press(vecs[i], 8, 12);
        end

        // Presses on different buttons two cycles apart settle independently: 7 -> 8 -> 7.
        @(negedge clk);
        bus.btn_inc = 1'b1;
        sb_q.push_back('{cyc + LAT, 5'd8, 1'b0});
        repeat (2) @(negedge clk);
        bus.btn_dec = 1'b1;
        sb_q.push_back('{cyc + LAT, 5'd7, 1'b0});
        repeat (8) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_dec = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-debounce with the button held through reset release.
        @(negedge clk);
        bus.btn_inc = 1'b1;
        repeat (3) @(posedge clk);
        async_reset(3);
        sb_q.push_back('{cyc + LAT, 5'd1, 1'b0});
        repeat (15) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (14) @(negedge clk);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_counter.md
# display_counter

Sequential front end for the two-digit seven-segment display path. Takes three raw push-button inputs and a 5-bit switch value, synchronizes and debounces each button, and maintains a 5-bit count (0–31). The count drives the `in` port of the downstream binary-to-two-digit-decimal seven-segment converter. Stage-wide signals use the codebase's standard `clk`/`reset` names.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized button level must differ from its debounced level before that level is accepted. Legal range 1..255.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_inc`  in  1  raw increment button; asynchronous to `clk`, may bounce.
- `btn_dec`  in  1  raw decrement button; same properties.
- `btn_load`  in  1  raw load button; same properties.
- `load_val`  in  5  switch value; sampled only on a load press.
- `count`  out  5  current count; feeds the display converter.
- `wrapped`  out  1  one-cycle pulse when an increment or decrement wraps.

## Operation
- Per-button chain, instantiated identically for inc, dec and load:
  - 2-flop synchronizer: `s1` then `s2`.
  - Debouncer: debounce counter `dcnt` plus `stable` flag.
  - Edge detect: `stable_d` register.
- Debouncer, evaluated each edge:
  - `s2 == stable`: `dcnt` <= 0.
  - `s2 != stable` and `dcnt == DEBOUNCE_CYCLES-1`: `stable` <= `s2`, `dcnt` <= 0.
  - Otherwise: `dcnt` <= `dcnt`+1.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronization is rejected, because `dcnt` restarts.
- Press pulse: `press = stable & ~stable_d`, combinational. `stable_d` <= `stable` each edge.
  - One press per debounced rising level.
  - Release produces no action.
  - A held button produces exactly one press; there is no auto-repeat.
- Count update on the edge where presses are observed. Priority, highest first:
  1. load press: `count` <= `load_val`. All values 0..31 are legal. `wrapped` = 0.
  2. inc and dec press in the same cycle: no change, `wrapped` = 0.
  3. inc press: `count` <= `count`+1, modulo 32. 31 -> 0 sets `wrapped` = 1 for that cycle.
  4. dec press: `count` <= `count`-1, modulo 32. 0 -> 31 sets `wrapped` = 1 for that cycle.
  5. No press: hold. `wrapped` = 0.
- Arithmetic is 5-bit unsigned. The carry/borrow out is the wrap indication; no saturation.
- `wrapped` is registered and deasserts on the next edge unless another wrap occurs.

## Timing
- Reset values, applied immediately on `reset` assertion with no clock required: `count` = 0, `wrapped` = 0. All `s1`, `s2`, `stable`, `stable_d` = 0 and all `dcnt` = 0.
- Reset asserted mid-debounce or mid-press discards all pending state.
- A button held high across reset deassertion produces a press after the normal latency, because `stable` restarts at 0.
- Latency for a clean button rise first sampled by `s1` at edge k:
  - `s2` = 1 after edge k+1.
  - `stable` = 1 after edge k+1+D, where D = `DEBOUNCE_CYCLES`.
  - `count` and `wrapped` update at edge k+2+D.
  - With D = 4: `count` changes 6 edges after first sample.
- Release latency is the same, k+1+D for `stable` to fall; it has no effect on `count`.
- Presses on different buttons settle independently. Only presses that fall in the same cycle interact, under the priority above.
- Minimum press width for acceptance: D cycles of stable synchronized level. Minimum gap between two accepted presses: 2D cycles (D high plus D low).
- `count` is a registered output; no combinational path from any input to `count` or `wrapped`.

## Test plan
All scenarios use D = 4 and start from reset.
- Reset: assert `reset` mid-cycle, no clock edge -> `count` = 00000 and `wrapped` = 0 immediately. Then hold `btn_inc` high for 20 cycles -> `count` = 1 exactly 6 edges after the first sample, stays 1 (no auto-repeat).
- Bounce rejection: pulse `btn_inc` high for 3 cycles, low 1 cycle, repeated 5 times, then low -> `count` stays 0. Then a clean 10-cycle press -> `count` = 1.
- Increment wrap: load 31 via `load_val` = 11111 and `btn_load` -> `count` = 31. Then one clean inc press -> `count` = 0 with `wrapped` = 1 for exactly one cycle.
- Decrement wrap: from 0, one dec press -> `count` = 31 with `wrapped` pulse. Then a second dec press -> 30, `wrapped` = 0.
- Simultaneous presses: `btn_inc` and `btn_dec` rising on the same cycle from `count` = 5 -> `count` stays 5. `btn_load` with `load_val` = 10110 rising together with `btn_inc` -> `count` = 22.
- Reset mid-operation: start an inc press, assert `reset` 3 cycles after first sample, release `reset` with the button still held -> `count` = 0 during reset, then `count` = 1 six edges after the first post-reset sample.
